sar_adc_ctrl: RTL and testbench
===============================

Name: sar_adc_ctrl

Overview:
- Successive-approximation ADC controller.
- Drives a trial code into the SoC's 10-bit resistor-string DAC and reads back a single analog comparator bit (Vin >= Vdac).
- Resolves one bit per cycle, MSB first, and returns a WIDTH-bit sample to the RISC-V core over a valid/ready handshake.
- Clocked from the PLL clock domain, alongside the core.

Parameters:
- WIDTH, 10, conversion resolution in bits; matches the DAC input width.
- SAMPLE_CYCLES, 4, track/hold acquisition cycles before bit trials (legal 1..15).

Ports:
- clk  input  1  PLL-derived system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- cmp_in  input  1  comparator result; 1 = Vin >= Vdac(dac_code); already synchronised and settled within one cycle of a dac_code change.
- dac_code  output  WIDTH  trial code to the DAC.
- sample_en  output  1  track/hold switch closed (tracking) when 1.
- busy  output  1  high in SAMPLE and CONVERT.
- data  output  WIDTH  last completed conversion result.
- data_valid  output  1  data holds an unconsumed result.
- data_ready  input  1  consumer accepts data when data_valid & data_ready.
- overrun  output  1  sticky: a result was overwritten before being consumed.

Behaviour:
- Reset (synchronous, any state, including mid-conversion):
  - state = IDLE; dac_code, data, result register, bit index and counters = 0.
  - sample_en, busy, data_valid, overrun = 0.
  - A conversion in progress is abandoned and produces no result.
- States: IDLE, SAMPLE, CONVERT.
  - IDLE: busy=0, sample_en=0, dac_code holds its last value. start=1 -> SAMPLE. start is ignored in SAMPLE/CONVERT; no queuing.
  - SAMPLE: sample_en=1, busy=1, dac_code=0, acquisition counter loaded with SAMPLE_CYCLES-1. Stays exactly SAMPLE_CYCLES cycles, then -> CONVERT with bit index i=WIDTH-1 and result=0.
  - CONVERT: sample_en=0, busy=1. Each cycle, dac_code = result | (1<<i). At the cycle-ending edge:
    - result[i] = cmp_in.
    - If i==0: go to IDLE, load data with the final result, set dac_code to the final result.
    - Otherwise: i decrements.
  - CONVERT lasts exactly WIDTH cycles.
- Latency:
  - start sampled at edge 0 -> SAMPLE cycles 1..SAMPLE_CYCLES -> CONVERT cycles SAMPLE_CYCLES+1..SAMPLE_CYCLES+WIDTH.
  - data/data_valid visible from cycle SAMPLE_CYCLES+WIDTH+1 (cycle 15 at defaults).
  - Back-to-back conversions: start held high gives a new SAMPLE at cycle 16, i.e. one IDLE cycle between conversions.
- Handshake:
  - data_valid rises on completion.
  - data_valid falls the cycle after data_valid & data_ready.
  - data is stable while data_valid=1 unless overrun occurs.
  - data_ready while data_valid=0 has no effect.
- Overrun:
  - A completion while data_valid=1 and data_ready=0 overwrites data, keeps data_valid=1, and sets overrun.
  - Completion in the same cycle as a handshake: the old data is consumed, new data is loaded, data_valid stays 1, and overrun is not set.
  - overrun clears only on reset.
- Arithmetic:
  - For an ideal comparator (cmp_in = Vin_code >= dac_code), data equals Vin_code exactly for all 0..2^WIDTH-1.
  - cmp_in stuck 1 -> all ones; cmp_in stuck 0 -> 0.
  - No wrap-around is possible.

Test Plan:
- Bench model cmp_in = (vin >= dac_code), vin=0x2A5, pulse start at cycle 0 -> sample_en high cycles 1-4; dac_code sequence 0x200,0x300,0x280,0x2C0,0x2A0,0x2B0,0x2A8,0x2A4,0x2A6,0x2A5; data=0x2A5 with data_valid=1 at cycle 15; busy low at cycle 15.
- Boundaries: vin=0x000 -> data=0x000; vin=0x3FF -> data=0x3FF. Each takes 14 busy cycles and sets no overrun.
- Start pulsed again at cycles 3 and 9 during the vin=0x155 conversion -> ignored; exactly one result 0x155, next SAMPLE only after a start in IDLE.
- data_ready held 0, vin=0x100 then a second conversion with vin=0x0FF -> data=0x0FF, data_valid=1, overrun=1. Raise data_ready -> data_valid falls the next cycle, overrun stays 1.
- Completion cycle coincides with data_ready=1 on a pending result -> new data loaded, data_valid remains 1, overrun=0.
- reset asserted for 1 cycle at cycle 8 (mid-CONVERT) -> next cycle IDLE, dac_code=0, busy=0, data_valid=0; no result produced. A fresh start then converts correctly.

Source files
------------

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: samples the input, then resolves
// one bit per cycle MSB-first against a resistor-string DAC and a comparator.
module sar_adc_ctrl #(
  parameter int WIDTH         = 10,
  parameter int SAMPLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic             sample_en,
  output logic             busy,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [IW-1:0]    bit_reg, bit_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [WIDTH-1:0] dac_reg, dac_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             data_valid_reg, data_valid_next;
  logic             overrun_reg, overrun_next;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] resolved;
  logic             done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      bit_reg        <= '0;
      result_reg     <= '0;
      dac_reg        <= '0;
      data_reg       <= '0;
      data_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bit_reg        <= bit_next;
      result_reg     <= result_next;
      dac_reg        <= dac_next;
      data_reg       <= data_next;
      data_valid_reg <= data_valid_next;
      overrun_reg    <= overrun_next;
    end
  end

  // Bits below the current index are still zero, so OR-ing is enough.
  assign trial    = result_reg | (WIDTH'(1) << bit_reg);
  assign resolved = result_reg | (WIDTH'(cmp_in) << bit_reg);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    bit_next        = bit_reg;
    result_next     = result_reg;
    dac_next        = dac_reg;
    data_next       = data_reg;
    data_valid_next = data_valid_reg;
    overrun_next    = overrun_reg;
    done            = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SAMPLE;
          cnt_next   = 4'(SAMPLE_CYCLES - 1);
          dac_next   = '0;
        end
      end
      SAMPLE: begin
        if (cnt_reg == 4'd0) begin
          state_next  = CONVERT;
          bit_next    = IW'(WIDTH - 1);
          result_next = '0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      CONVERT: begin
        result_next = resolved;
        if (bit_reg == '0) begin
          state_next = IDLE;
          dac_next   = resolved;
          data_next  = resolved;
          done       = 1'b1;
        end else begin
          bit_next = bit_reg - IW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // A completion wins over a same-cycle handshake: the old word is consumed
    // and the new one becomes valid without flagging an overrun.
    if (done) begin
      data_valid_next = 1'b1;
      if (data_valid_reg && !data_ready)
        overrun_next = 1'b1;
    end else if (data_valid_reg && data_ready) begin
      data_valid_next = 1'b0;
    end
  end

  assign dac_code   = (state_reg == CONVERT) ? trial : dac_reg;
  assign sample_en  = (state_reg == SAMPLE);
  assign busy       = (state_reg != IDLE);
  assign data       = data_reg;
  assign data_valid = data_valid_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl: stimulus queues expected samples, a
// monitor pops and compares each time a conversion completes.
module tb_sar_adc_ctrl;

  localparam int WIDTH = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             cmp_in;
  logic [WIDTH-1:0] dac_code;
  logic             sample_en;
  logic             busy;
  logic [WIDTH-1:0] data;
  logic             data_valid;
  logic             data_ready;
  logic             overrun;

  logic [WIDTH-1:0] vin;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] seq[10];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic             busy_prev = 1'b0;

  sar_adc_ctrl #(.WIDTH(WIDTH), .SAMPLE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cmp_in     (cmp_in),
    .dac_code   (dac_code),
    .sample_en  (sample_en),
    .busy       (busy),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Ideal comparator model
  always_comb cmp_in = (vin >= dac_code);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a result is presented when busy drops with data_valid set
  always @(negedge clk) begin
    if (!reset && busy_prev && !busy && data_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {22'd0, data}, 32'hFFFF_FFFF);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        $display("result data=0x%03h expected=0x%03h overrun=%0b", data, e, overrun);
        chk("result_data", {22'd0, data}, {22'd0, e});
      end
    end
    busy_prev = busy;
  end

  // Full conversion from IDLE; checks the busy window length.
  task automatic run_conv(input logic [WIDTH-1:0] v);
    int n;
    vin   = v;
    start = 1'b1;
    exp_q.push_back(v);
    step();
    start = 1'b0;
    n = 0;
    while (busy && n < 60) begin
      n++;
      step();
    end
    chk("busy_cycles", n, 14);
  endtask

  initial begin
    seq = '{10'h200, 10'h300, 10'h280, 10'h2C0, 10'h2A0,
            10'h2B0, 10'h2A8, 10'h2A4, 10'h2A6, 10'h2A5};
    reset = 1'b1; start = 1'b0; data_ready = 1'b1; vin = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_dac_code", {22'd0, dac_code}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_sample_en", {31'd0, sample_en}, 0);
    chk("rst_data_valid", {31'd0, data_valid}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    chk("rst_data", {22'd0, data}, 0);

    // Detailed trace, vin = 0x2A5
    vin = 10'h2A5; start = 1'b1; exp_q.push_back(10'h2A5);
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("sample_en_c%0d", c), {31'd0, sample_en}, 1);
      chk($sformatf("busy_c%0d", c), {31'd0, busy}, 1);
      chk($sformatf("sample_dac_c%0d", c), {22'd0, dac_code}, 0);
      step();
    end
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("dac_seq_%0d", k), {22'd0, dac_code}, {22'd0, seq[k]});
      chk($sformatf("conv_sample_en_%0d", k), {31'd0, sample_en}, 0);
      step();
    end
    chk("c15_busy", {31'd0, busy}, 0);
    chk("c15_valid", {31'd0, data_valid}, 1);
    chk("c15_data", {22'd0, data}, 32'h2A5);
    chk("c15_dac_hold", {22'd0, dac_code}, 32'h2A5);
    step();

    // Boundaries
    run_conv(10'h000);
    chk("zero_overrun", {31'd0, overrun}, 0);
    step();
    run_conv(10'h3FF);
    chk("full_overrun", {31'd0, overrun}, 0);
    step();

    // start pulses during a conversion are ignored
    vin = 10'h155; start = 1'b1; exp_q.push_back(10'h155);
    step();
    for (int c = 1; c <= 14; c++) begin
      start = (c == 3 || c == 9);
      step();
    end
    start = 1'b0;
    chk("ign_busy_c15", {31'd0, busy}, 0);
    for (int c = 0; c < 5; c++) step();
    chk("ign_no_restart", {31'd0, busy}, 0);

    // Overrun with data_ready held low
    data_ready = 1'b0;
    run_conv(10'h100);
    run_conv(10'h0FF);
    chk("ovr_data", {22'd0, data}, 32'h0FF);
    chk("ovr_valid", {31'd0, data_valid}, 1);
    chk("ovr_flag", {31'd0, overrun}, 1);
    data_ready = 1'b1;
    step();
    chk("ovr_valid_fall", {31'd0, data_valid}, 0);
    chk("ovr_sticky", {31'd0, overrun}, 1);

    // Completion coinciding with a handshake
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst2_overrun", {31'd0, overrun}, 0);
    data_ready = 1'b0;
    run_conv(10'h0AA);
    vin = 10'h333; start = 1'b1; exp_q.push_back(10'h333);
    step();
    start = 1'b0;
    for (int c = 1; c <= 13; c++) step();
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    chk("coin_valid", {31'd0, data_valid}, 1);
    chk("coin_data", {22'd0, data}, 32'h333);
    chk("coin_overrun", {31'd0, overrun}, 0);
    data_ready = 1'b1;
    step();
    chk("coin_consumed", {31'd0, data_valid}, 0);

    // Reset mid-CONVERT at cycle 8
    vin = 10'h2A5; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) step();
    chk("pre_rst_busy", {31'd0, busy}, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_dac", {22'd0, dac_code}, 0);
    chk("mid_rst_valid", {31'd0, data_valid}, 0);
    for (int c = 0; c < 20; c++) step();
    chk("mid_rst_no_result", {31'd0, data_valid}, 0);
    run_conv(10'h1C3);
    chk("fresh_data", {22'd0, data}, 32'h1C3);

    for (int c = 0; c < 4; c++) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
